serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//  Sequencer for the bit-serial adder datapath. Accepts two WIDTH-bit operands
//  on a start strobe, streams them LSB-first through a 1-bit carry-state adder
//  cell and collects the sum bits. Reports sum, carry-out and signed overflow
//  with a one-cycle done pulse. Supports add and two's-complement subtract.
//  Sits between the lab-board operand registers and the result display logic.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
//  CNT_W   derived localparam = $clog2(WIDTH); bit-position counter width
// PORTS
//  clk      in   1      clock
//  rst      in   1      reset: synchronous, active-high
//  start    in   1      begin operation; sampled only in IDLE or DONE
//  sub      in   1      0 = A+B, 1 = A-B; sampled with start
//  en       in   1      step enable; 0 freezes SHIFT (no bit consumed)
//  a_in     in   WIDTH  operand A; sampled with start
//  b_in     in   WIDTH  operand B; sampled with start
//  busy     out  1      high while in SHIFT
//  done     out  1      one-cycle pulse, high only in DONE
//  sum_out  out  WIDTH  result; held until the next completion
//  cout     out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf      out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, sum_out=0, cout=0, ovf=0, counter=0,
//    operand/result shift regs=0, cell carry=0. rst has priority over all.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE : start=1 -> SHIFT; load a_sh=a_in, b_sh=sub ? ~b_in : b_in,
//           cell carry=sub, cnt=0. start=0 -> stay.
//    SHIFT: en=1 -> consume bit: s = a_sh[0]^b_sh[0]^c; c' = majority;
//           res_sh = {s, res_sh[WIDTH-1:1]}; a_sh, b_sh shift right; cnt++.
//           Capture carry-in of MSB when cnt==WIDTH-1. On the edge that
//           consumes bit WIDTH-1: register sum_out, cout=c', ovf, -> DONE.
//           en=0 -> all state frozen, no cnt advance.
//    DONE : done=1 for exactly this cycle. start=1 -> SHIFT with new load
//           (back-to-back); else -> IDLE.
//  - Latency: start sampled at edge E0; done high in the cycle after edge
//    E0+WIDTH (plus one cycle per en=0 cycle in SHIFT). busy high for the
//    WIDTH cycles after E0 (plus stalls).
//  - start while in SHIFT: ignored; operands/sub not re-sampled.
//  - en is ignored outside SHIFT (loads and DONE->IDLE proceed regardless).
//  - rst mid-SHIFT: abort; no done pulse; outputs return to reset values.
//  - Arithmetic is modulo 2^WIDTH; cout/ovf carry the extra information.
// STRUCTURE
//  - Shared header serial_add_defs.vh: state encodings (IDLE=2'd0, SHIFT=2'd1,
//    DONE=2'd2) and default WIDTH; also included by the testbench.
//  - One sub-module: serial_add_cell (clk, rst, en, ld, cin_init, a, b ->
//    s, c): 1-bit carry-state full-adder cell; ld forces carry=cin_init.
//  - Controller owns FSM, counter, operand/result shift registers.
// TESTING
//  1. add a=8'h5A b=8'h33 en=1 -> done 9 cycles after start edge,
//     sum_out=8'h8D cout=0 ovf=1.
//  2. add a=8'hFF b=8'h01 -> sum_out=8'h00 cout=1 ovf=0.
//  3. sub a=8'h10 b=8'h20 -> 8'hF0 cout=0 ovf=0; sub a=8'h80 b=8'h01
//     -> 8'h7F cout=1 ovf=1.
//  4. case 1 with en=0 for 3 cycles after bit 3 -> done exactly 3 cycles
//     later, result unchanged; busy stays high during stall.
//  5. start with a=8'hAA during SHIFT -> ignored, case 1 result intact;
//     rst at bit 4 -> busy=0 next cycle, no done, sum_out=0.
//  6. start held high, operands changed each op -> done every WIDTH+1
//     cycles via DONE->SHIFT, each result correct.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
// Imported by the controller and by the testbench.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_cell.sv
// One-bit full-adder cell with a registered carry.
// Loading forces the carry to cin_init, which is 1 for two's-complement subtract.
module serial_add_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ld,
  input  logic cin_init,
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  logic carry;

  always_ff @(posedge clk) begin
    if (rst)
      carry <= 1'b0;
    else if (ld)
      carry <= cin_init;
    else if (en)
      carry <= c;
  end

  // s and c describe the bit currently presented; c becomes the next carry state
  assign s = a ^ b ^ carry;
  assign c = (a & b) | (a & carry) | (b & carry);

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the bit-serial adder: loads operands, streams them LSB-first
// through serial_add_cell and reports sum, carry-out and signed overflow.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             en,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             load, step, last;
  logic             s_bit, c_bit, cin_msb;

  serial_add_cell u_cell (
    .clk      (clk),
    .rst      (rst),
    .en       (step),
    .ld       (load),
    .cin_init (sub),
    .a        (a_sh[0]),
    .b        (b_sh[0]),
    .s        (s_bit),
    .c        (c_bit)
  );

  assign last    = (cnt == CNT_W'(WIDTH - 1));
  // The carry into the MSB is recovered from the sum bit, saving a capture register
  assign cin_msb = s_bit ^ a_sh[0] ^ b_sh[0];
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (en) begin
          step = 1'b1;
          if (last)
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sh <= a_in;
        b_sh <= sub ? ~b_in : b_in;
        cnt  <= '0;
      end else if (step) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {s_bit, res_sh[WIDTH-1:1]};
        cnt    <= cnt + 1'b1;
        if (last) begin
          sum_out <= {s_bit, res_sh[WIDTH-1:1]};
          cout    <= c_bit;
          ovf     <= cin_msb ^ c_bit;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard testbench for serial_add_ctrl: directed and random add/sub operations,
// stalls, back-to-back starts and a mid-operation reset, checked against an arithmetic model.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst, start, sub, en;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum_out;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    time          t;
  } exp_t;

  exp_t         scoreboard[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sub     (sub),
    .en      (en),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic and sign rules
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t r;
    int   ai, bi, full;
    ai     = int'(a);
    bi     = int'(b);
    full   = s ? (ai - bi) : (ai + bi);
    r.sum  = full[W-1:0];
    r.cout = s ? (ai >= bi) : (full >= (1 << W));
    if (s)
      r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    else
      r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    r.t = 0;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest expected result, half a cycle after its last edge
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("sum_out", 64'(sum_out), 64'(e.sum));
        checkOutput("cout", 64'(cout), 64'(e.cout));
        checkOutput("ovf", 64'(ovf), 64'(e.ovf));
        checkOutput("done_latency", 64'($time - e.t), 64'd5);
      end
    end
  end

  // Called at a negedge in IDLE or DONE; returns at the negedge of the DONE cycle
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               input int stall_at, input int stall_len, input bit rnd);
    exp_t e;
    int   consumed = 0;
    int   stalled  = 0;
    int   iter     = 0;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub   = s;
    en    = 1'($urandom_range(0, 1));
    @(posedge clk);
    while (consumed < W && iter < 200) begin
      @(negedge clk);
      iter++;
      checkOutput("busy_in_shift", 64'(busy), 64'd1);
      start = 1'($urandom_range(0, 1));
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      sub   = 1'($urandom_range(0, 1));
      if (stall_at >= 0 && consumed == stall_at && stalled < stall_len) begin
        en = 1'b0;
        stalled++;
      end else if (rnd) begin
        en = ($urandom_range(0, 3) != 0);
      end else begin
        en = 1'b1;
      end
      @(posedge clk);
      if (en) consumed++;
    end
    if (consumed < W)
      checkOutput("shift_timeout", 64'(consumed), 64'(W));
    e   = model(a, b, s);
    e.t = $time;
    scoreboard.push_back(e);
    last_sum  = e.sum;
    last_cout = e.cout;
    last_ovf  = e.ovf;
    @(negedge clk);
  endtask

  task automatic goIdle();
    start = 1'b0;
    en    = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("held_sum", 64'(sum_out), 64'(last_sum));
    checkOutput("held_cout", 64'(cout), 64'(last_cout));
    checkOutput("held_ovf", 64'(ovf), 64'(last_ovf));
  endtask

  task automatic resetMidShift(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    sub   = 1'b0;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      en    = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_sum", 64'(sum_out), 64'd0);
    checkOutput("abort_cout", 64'(cout), 64'd0);
    checkOutput("abort_ovf", 64'(ovf), 64'd0);
    rst       = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    last_ovf  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    en    = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_sum", 64'(sum_out), 64'd0);
    checkOutput("reset_cout", 64'(cout), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    applyStimulus(8'h5A, 8'h33, 1'b0, -1, 0, 1'b0); goIdle();
    applyStimulus(8'hFF, 8'h01, 1'b0, -1, 0, 1'b0); goIdle();
    applyStimulus(8'h10, 8'h20, 1'b1, -1, 0, 1'b0); goIdle();
    applyStimulus(8'h80, 8'h01, 1'b1, -1, 0, 1'b0); goIdle();
    applyStimulus(8'h5A, 8'h33, 1'b0, 4, 3, 1'b0);  goIdle();

    resetMidShift(8'h5A, 8'h33);
    goIdle();

    for (int i = 0; i < 6; i++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1, 0, 1'b0);
    goIdle();

    for (int i = 0; i < 40; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) goIdle();
    end
    goIdle();

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(scoreboard.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
